// File: rtl/fp_norm_round_seq_pkg.sv
// Shared encodings for the FP normalise/round sequencer.
// State codes, exponent limits and GRS bit positions.
package fp_norm_round_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int         BIAS    = 127;
  localparam int         EXP_LIM = 2 * BIAS + 1;

  localparam int LSB_BIT = 3;
  localparam int G_BIT   = 2;
  localparam int R_BIT   = 1;
  localparam int S_BIT   = 0;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } flags_t;

endpackage

// File: rtl/pr_enc27.sv
// 27-bit leading-zero encoder.
// zero is set when no bit of a is high.
module pr_enc27 (
  input  logic [26:0] a,
  output logic [4:0]  lz,
  output logic        zero
);

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (a[i]) lz = 5'(26 - i);
    end
  end

  assign zero = ~|a;

endmodule

// File: rtl/fp_norm_round_seq.sv
// Normalise, round and pack a raw FP adder sum to binary32.
// Four-state sequencer with valid/ready on both sides.
module fp_norm_round_seq
  import fp_norm_round_seq_pkg::*;
#(
  parameter int RND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic        in_carry,
  input  logic [26:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inx
);

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               carry_q, carry_d;
  logic [26:0]        mant_q, mant_d;
  logic               done_q, done_d;
  logic [31:0]        data_q, data_d;
  flags_t             flg_q, flg_d;

  logic [4:0]         lz;
  logic               mzero;
  logic               rnd_inc;
  logic [24:0]        sig;
  logic signed [9:0]  exp_r;
  logic [2:0]         grs;

  pr_enc27 u_enc (
    .a    (mant_q),
    .lz   (lz),
    .zero (mzero)
  );

  assign grs = {mant_q[G_BIT], mant_q[R_BIT], mant_q[S_BIT]};

  assign rnd_inc = (RND_MODE == 0) && mant_q[G_BIT] &&
                   (mant_q[R_BIT] | mant_q[S_BIT] | mant_q[LSB_BIT]);

  assign sig   = {1'b0, mant_q[26:3]} + {24'd0, rnd_inc};
  // Significand carry-out leaves 1.0 in sig, so only the exponent moves.
  assign exp_r = exp_q + (sig[24] ? 10'sd1 : 10'sd0);

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    carry_d = carry_q;
    mant_d  = mant_q;
    done_d  = done_q;
    data_d  = data_q;
    flg_d   = flg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = $signed({2'b00, in_exp});
          carry_d = in_carry;
          mant_d  = in_mant;
          done_d  = 1'b0;
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        state_d = ST_ROUND;
        if (exp_q[7:0] == EXP_MAX) begin
          data_d = {sign_q, EXP_MAX, mant_q[25:3]};
          flg_d  = '0;
          done_d = 1'b1;
        end else if (carry_q) begin
          mant_d = {1'b1, mant_q[26:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + 10'sd1;
        end else if (mzero) begin
          data_d = 32'd0;
          flg_d  = '0;
          done_d = 1'b1;
        end else if ($signed({5'd0, lz}) >= exp_q) begin
          data_d = {sign_q, 31'd0};
          flg_d  = '{ovf: 1'b0, unf: 1'b1, inx: 1'b1};
          done_d = 1'b1;
        end else begin
          mant_d = mant_q << lz;
          exp_d  = exp_q - $signed({5'd0, lz});
        end
      end
      ST_ROUND: begin
        state_d = ST_HOLD;
        if (!done_q) begin
          if (int'(exp_r) >= EXP_LIM) begin
            data_d = {sign_q, EXP_MAX, 23'd0};
            flg_d  = '{ovf: 1'b1, unf: 1'b0, inx: 1'b1};
          end else begin
            data_d = {sign_q, exp_r[7:0], sig[22:0]};
            flg_d  = '{ovf: 1'b0, unf: 1'b0, inx: |grs};
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      carry_q <= 1'b0;
      mant_q  <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      carry_q <= carry_d;
      mant_q  <= mant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      flg_q   <= flg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign out_ovf   = flg_q.ovf;
  assign out_unf   = flg_q.unf;
  assign out_inx   = flg_q.inx;

endmodule

// File: tb/tb_fp_norm_round_seq.sv
// Directed bench for fp_norm_round_seq.
// Runs a round-to-nearest and a truncating instance side by side.
module tb_fp_norm_round_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic        in_carry;
  logic [26:0] in_mant;
  logic        out_ready;

  logic        rdy_n, vld_n, ovf_n, unf_n, inx_n;
  logic        rdy_z, vld_z, ovf_z, unf_z, inx_z;
  logic [31:0] dat_n, dat_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_norm_round_seq #(.RND_MODE(0)) u_rne (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_n),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_carry(in_carry), .in_mant(in_mant),
    .out_valid(vld_n), .out_ready(out_ready),
    .out_data(dat_n),
    .out_ovf(ovf_n), .out_unf(unf_n), .out_inx(inx_n)
  );

  fp_norm_round_seq #(.RND_MODE(1)) u_rtz (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy_z),
    .in_sign(in_sign), .in_exp(in_exp),
    .in_carry(in_carry), .in_mant(in_mant),
    .out_valid(vld_z), .out_ready(out_ready),
    .out_data(dat_z),
    .out_ovf(ovf_z), .out_unf(unf_z), .out_inx(inx_z)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] e,
                       input logic c, input logic [26:0] m);
    in_sign  = s;
    in_exp   = e;
    in_carry = c;
    in_mant  = m;
    in_valid = 1'b1;
  endtask

  // flags argument order: {ovf, unf, inx}
  task automatic run_op(input string tag,
                        input logic s, input logic [7:0] e,
                        input logic c, input logic [26:0] m,
                        input logic [31:0] dn, input logic [2:0] fn,
                        input logic [31:0] dz, input logic [2:0] fz);
    chk({tag, ".idle"}, {31'd0, rdy_n}, 32'd1);
    drive(s, e, c, m);
    tick();
    in_valid = 1'b0;
    chk({tag, ".busy"}, {31'd0, rdy_n}, 32'd0);
    tick();
    chk({tag, ".early"}, {31'd0, vld_n}, 32'd0);
    tick();
    chk({tag, ".vld"}, {30'd0, vld_n, vld_z}, 32'd3);
    chk({tag, ".rne"}, dat_n, dn);
    chk({tag, ".rne_f"}, {29'd0, ovf_n, unf_n, inx_n}, {29'd0, fn});
    chk({tag, ".rtz"}, dat_z, dz);
    chk({tag, ".rtz_f"}, {29'd0, ovf_z, unf_z, inx_z}, {29'd0, fz});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".done"}, {30'd0, rdy_n, vld_n}, 32'd2);
  endtask

  logic [31:0] held;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_carry  = 1'b0;
    in_mant   = 27'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.hs", {30'd0, rdy_n, vld_n}, 32'd2);
    chk("rst.data", dat_n, 32'd0);
    chk("rst.flg", {29'd0, ovf_n, unf_n, inx_n}, 32'd0);

    run_op("carry", 0, 8'd127, 1, 27'h0000000,
           32'h40000000, 3'b000, 32'h40000000, 3'b000);
    run_op("cancel", 0, 8'd127, 0, 27'h0000008,
           32'h34000000, 3'b000, 32'h34000000, 3'b000);
    run_op("tie_up", 0, 8'd127, 0, 27'h400000C,
           32'h3F800002, 3'b001, 32'h3F800001, 3'b001);
    run_op("tie_even", 0, 8'd127, 0, 27'h4000004,
           32'h3F800000, 3'b001, 32'h3F800000, 3'b001);
    run_op("ovf", 0, 8'd254, 1, 27'h0000000,
           32'h7F800000, 3'b101, 32'h7F800000, 3'b101);
    run_op("unf", 0, 8'd5, 0, 27'h0000008,
           32'h00000000, 3'b011, 32'h00000000, 3'b011);
    run_op("zero", 1, 8'd100, 0, 27'h0000000,
           32'h00000000, 3'b000, 32'h00000000, 3'b000);
    run_op("special", 0, 8'hFF, 0, 27'h4000008,
           32'h7F800001, 3'b000, 32'h7F800001, 3'b000);
    run_op("rnd_co", 0, 8'd127, 0, 27'h7FFFFFC,
           32'h40000000, 3'b001, 32'h3FFFFFFF, 3'b001);
    run_op("neg", 1, 8'd127, 0, 27'h4000000,
           32'hBF800000, 3'b000, 32'hBF800000, 3'b000);
    run_op("lz_eq", 1, 8'd23, 0, 27'h0000008,
           32'h80000000, 3'b011, 32'h80000000, 3'b011);
    run_op("lz_lt", 0, 8'd24, 0, 27'h0000008,
           32'h00800000, 3'b000, 32'h00800000, 3'b000);
    run_op("sticky", 0, 8'd127, 1, 27'h0000001,
           32'h40000000, 3'b001, 32'h40000000, 3'b001);

    // back-pressure with stray in_valid pulses while busy
    drive(0, 8'd127, 0, 27'h400000C);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    held = 32'h3F800002;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      drive(1, 8'(10 + i), 1, 27'h1234567);
      in_valid = i[0];
      tick();
      chk("bp.vld", {31'd0, vld_n}, 32'd1);
      chk("bp.rdy", {31'd0, rdy_n}, 32'd0);
      chk("bp.data", dat_n, held);
      chk("bp.flg", {29'd0, ovf_n, unf_n, inx_n}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.rel", {30'd0, rdy_n, vld_n}, 32'd2);
    tick();
    chk("bp.nocap", {30'd0, rdy_n, vld_n}, 32'd2);

    // reset while in NORM
    drive(0, 8'd254, 1, 27'h0000000);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.hs", {30'd0, rdy_n, vld_n}, 32'd2);
    chk("mrst.flg", {29'd0, ovf_n, unf_n, inx_n}, 32'd0);
    chk("mrst.data", dat_n, 32'd0);
    tick();
    tick();
    chk("mrst.quiet", {30'd0, rdy_n, vld_n}, 32'd2);
    run_op("post_rst", 0, 8'd127, 0, 27'h0000008,
           32'h34000000, 3'b000, 32'h34000000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
